// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-file write controller:
// register map, frame layout and controller state encoding.
package spi_ctrl_pkg;

   localparam logic [6:0] ADDR_EN_OUT_7_0   = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8  = 7'h01;
   localparam logic [6:0] ADDR_DRIVE_CFG    = 7'h02;
   localparam logic [6:0] ADDR_PWM_PERIOD   = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY     = 7'h04;
   localparam logic [6:0] MAX_ADDR          = ADDR_PWM_DUTY;

   localparam int FRAME_BITS = 16;
   localparam int WRITE_BIT  = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_e;

   // Write frame, MSB first: {write flag, 7-bit address, 8-bit data}.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] addr,
                                                         input logic [7:0] data);
      logic [FRAME_BITS-1:0] frame;
      frame            = {1'b0, addr, data};
      frame[WRITE_BIT] = 1'b1;
      return frame;
   endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the
// requester not served last wins; requester 0 is favoured out of reset.
module spi_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);

   // last_q = index of the requester served most recently
   logic last_q, last_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant_o = 2'b00;
      last_d  = last_q;
      if (en_i) begin
         unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
      if (grant_o[0]) begin
         last_d = 1'b0;
      end else if (grant_o[1]) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/spi_config_ctrl.sv
// SPI mode-0 write controller: arbitrates two requesters and shifts 16-bit
// write frames to a register-file peripheral, with a fixed nCS gap between frames.
module spi_config_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic [6:0] req_addr0,
   input  logic [6:0] req_addr1,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   output logic [1:0] req_ready,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic       err,
   output logic       nCS,
   output logic       SCLK,
   output logic       COPI
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   // The IDLE accept cycle also has nCS high, so GAP itself lasts one cycle
   // less and the nCS-high time between back-to-back frames is GAP_CYCLES.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);
   localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

   state_e                  state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [3:0]              bit_q, bit_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic                    sclk_q, sclk_d;
   logic                    id_q, id_d;
   logic                    done_q, done_d;
   logic                    done_id_q, done_id_d;
   logic                    err_q, err_d;
   logic                    from_gap_q, from_gap_d;

   logic                    accept;
   logic                    acc_id;
   logic [6:0]              acc_addr;
   logic [7:0]              acc_data;
   logic                    addr_ok;

   spi_rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (state_q == ST_IDLE),
      .req_i   (req_valid),
      .grant_o (req_ready)
   );

   assign accept   = |(req_valid & req_ready);
   assign acc_id   = req_ready[1];
   assign acc_addr = acc_id ? req_addr1 : req_addr0;
   assign acc_data = acc_id ? req_data1 : req_data0;
   assign addr_ok  = (acc_addr <= MAX_ADDR);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      gap_d      = gap_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      sclk_d     = sclk_q;
      id_d       = id_q;
      done_d     = 1'b0;
      done_id_d  = done_id_q;
      err_d      = 1'b0;
      from_gap_d = (state_q == ST_GAP);

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (addr_ok) begin
                  state_d = ST_SHIFT;
                  shreg_d = build_frame(acc_addr, acc_data);
                  id_d    = acc_id;
                  div_d   = '0;
                  bit_d   = '0;
                  sclk_d  = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               // Falling edge: present the next bit and retire the current one.
               if (sclk_q) begin
                  shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                  bit_d   = bit_q + 4'd1;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_HOLD;
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_HOLD: begin
            if (div_q == DIV_LAST) begin
               state_d   = ST_GAP;
               div_d     = '0;
               gap_d     = '0;
               done_d    = 1'b1;
               done_id_d = id_q;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         gap_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         sclk_q     <= 1'b0;
         id_q       <= 1'b0;
         done_q     <= 1'b0;
         done_id_q  <= 1'b0;
         err_q      <= 1'b0;
         from_gap_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         gap_q      <= gap_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         sclk_q     <= sclk_d;
         id_q       <= id_d;
         done_q     <= done_d;
         done_id_q  <= done_id_d;
         err_q      <= err_d;
         from_gap_q <= from_gap_d;
      end
   end

   // Outputs decode from state so reset forces the idle line levels at once.
   assign nCS     = !((state_q == ST_SHIFT) || (state_q == ST_HOLD));
   assign SCLK    = sclk_q;
   assign COPI    = (state_q == ST_SHIFT) && shreg_q[FRAME_BITS-1];
   // A valid accept straight out of GAP keeps busy high across the IDLE cycle.
   assign busy    = (state_q != ST_IDLE) || (from_gap_q && accept && addr_ok);
   assign done    = done_q;
   assign done_id = done_id_q;
   assign err     = err_q;

endmodule
